// File: rtl/alu_pkg.sv
// Shared ALU control codes, sequencer op encoding and state type for alu_muldiv_seq.
package alu_pkg;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   localparam logic OP_MUL  = 1'b0;
   localparam logic OP_DIVU = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DCMP,
      S_DSUB,
      S_DONE
   } seq_state_t;
endpackage

// File: rtl/ALU.sv
// Single-cycle 32-bit ALU; SLT is an unsigned compare.
module ALU
   import alu_pkg::*;
(
   input  logic [3:0]  ctrl,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result,
   output logic        zero
);
   always_comb begin
      result = '0;
      case (ctrl)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_SLT: result = {31'd0, (a < b)};
         ALU_NOR: result = ~(a | b);
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);
endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MUL (low word) / DIVU sequencer driving one private ALU,
// one ALU operation per cycle: shift-add multiply and restoring division.
module alu_muldiv_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi
);
   seq_state_t state, nstate;

   logic [WIDTH-1:0] acc, mc, mp;
   logic [WIDTH-1:0] rem, quo, dvs;
   logic             ovf, lt;
   logic [4:0]       cnt;

   logic [3:0]       alu_ctrl;
   logic [WIDTH-1:0] alu_a, alu_b, alu_res;
   logic             unused_zero;

   logic             accept, last;
   logic [WIDTH-1:0] rem_sh, rem_n, quo_n;

   ALU u_alu (
      .ctrl   (alu_ctrl),
      .a      (alu_a),
      .b      (alu_b),
      .result (alu_res),
      .zero   (unused_zero)
   );

   assign accept = start && (state == S_IDLE || state == S_DONE);
   assign last   = (cnt == 5'd31);
   assign rem_sh = {rem[WIDTH-2:0], quo[WIDTH-1]};
   assign busy   = (state == S_MUL) || (state == S_DCMP) || (state == S_DSUB);
   assign done   = (state == S_DONE);

   // Restoring step: subtract when the shifted remainder overflowed 32 bits
   // (so it certainly exceeds the divisor) or when it is not below the divisor.
   always_comb begin
      rem_n = rem;
      quo_n = quo;
      if (ovf || !lt) begin
         rem_n = alu_res;
         quo_n = quo | {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nstate;
   end

   always_comb begin
      nstate   = state;
      alu_ctrl = ALU_ADD;
      alu_a    = '0;
      alu_b    = '0;
      case (state)
         S_IDLE, S_DONE: begin
            nstate = S_IDLE;
            if (accept) begin
               if (op == OP_MUL)  nstate = S_MUL;
               else if (opb == '0) nstate = S_DONE;
               else               nstate = S_DCMP;
            end
         end
         S_MUL: begin
            alu_a = acc;
            alu_b = mp[0] ? mc : '0;
            if (last) nstate = S_DONE;
         end
         S_DCMP: begin
            alu_ctrl = ALU_SLT;
            alu_a    = rem_sh;
            alu_b    = dvs;
            nstate   = S_DSUB;
         end
         S_DSUB: begin
            alu_ctrl = ALU_SUB;
            alu_a    = rem;
            alu_b    = dvs;
            nstate   = last ? S_DONE : S_DCMP;
         end
         default: nstate = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         mc        <= '0;
         mp        <= '0;
         rem       <= '0;
         quo       <= '0;
         dvs       <= '0;
         ovf       <= 1'b0;
         lt        <= 1'b0;
         cnt       <= '0;
         result_lo <= '0;
         result_hi <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  result_lo <= '0;
                  result_hi <= '0;
                  cnt       <= '0;
                  if (op == OP_MUL) begin
                     acc <= '0;
                     mc  <= opa;
                     mp  <= opb;
                  end else if (opb == '0) begin
                     result_lo <= '1;
                     result_hi <= opa;
                  end else begin
                     rem <= '0;
                     quo <= opa;
                     dvs <= opb;
                  end
               end
            end
            S_MUL: begin
               acc <= alu_res;
               mc  <= {mc[WIDTH-2:0], 1'b0};
               mp  <= {1'b0, mp[WIDTH-1:1]};
               cnt <= cnt + 5'd1;
               if (last) result_lo <= alu_res;
            end
            S_DCMP: begin
               // rem holds the shifted remainder through DSUB
               rem <= rem_sh;
               quo <= {quo[WIDTH-2:0], 1'b0};
               ovf <= rem[WIDTH-1];
               lt  <= alu_res[0];
            end
            S_DSUB: begin
               rem <= rem_n;
               quo <= quo_n;
               cnt <= cnt + 5'd1;
               if (last) begin
                  result_lo <= quo_n;
                  result_hi <= rem_n;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq: directed MUL/DIVU vectors, latency and reset checks.
module tb_alu_muldiv_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic [31:0] opa = '0, opb = '0;
   logic        busy, done;
   logic [31:0] result_lo, result_hi;

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      int          lat;
      int          t0;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   alu_muldiv_seq #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op        (op),
      .opa       (opa),
      .opb       (opb),
      .busy      (busy),
      .done      (done),
      .result_lo (result_lo),
      .result_hi (result_hi)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result_lo", result_lo, e.lo);
            chk("result_hi", result_hi, e.hi);
            chk("latency", 32'(cyc + 1 - e.t0), 32'(e.lat));
            chk("busy_in_done", {31'd0, busy}, 32'd0);
         end
      end
   end

   // Called at a negedge; start is sampled at the following posedge (T).
   task automatic drive(input logic o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] elo, input logic [31:0] ehi, input int elat);
      exp_t e;
      e.lo = elo; e.hi = ehi; e.lat = elat; e.t0 = cyc + 1;
      sb.push_back(e);
      start = 1'b1; op = o; opa = a; opb = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy_after_start", {31'd0, busy}, (elat == 1) ? 32'd0 : 32'd1);
   endtask

   // Leaves the caller at the negedge where done is high.
   task automatic wait_done();
      int n = 0;
      @(negedge clk);
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!done) chk("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_lo", result_lo, 32'd0);
      chk("rst_hi", result_hi, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      drive(1'b0, 32'd7, 32'd6, 32'd42, 32'd0, 33);                  wait_done();
      @(negedge clk);
      drive(1'b0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd0, 33);   wait_done();
      @(negedge clk);
      drive(1'b0, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0, 33);   wait_done();
      @(negedge clk);
      drive(1'b0, 32'h1234_5678, 32'h10, 32'h2345_6780, 32'd0, 33);  wait_done();
      @(negedge clk);
      drive(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 65);                wait_done();
      @(negedge clk);
      drive(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 65); wait_done();
      @(negedge clk);
      drive(1'b1, 32'd7, 32'd100, 32'd0, 32'd7, 65);                 wait_done();
      @(negedge clk);
      drive(1'b1, 32'hDEAD_BEEF, 32'd1, 32'hDEAD_BEEF, 32'd0, 65);   wait_done();
      @(negedge clk);
      drive(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1);            wait_done();
      // Back-to-back: start while done is high
      drive(1'b0, 32'd1000, 32'd1000, 32'h000F_4240, 32'd0, 33);
      repeat (5) @(negedge clk);
      start = 1'b1; op = 1'b1; opa = 32'd9; opb = 32'd0;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      drive(1'b1, 32'd50, 32'd5, 32'd10, 32'd0, 65);                 wait_done();
      @(negedge clk);

      // Reset in the middle of a divide
      drive(1'b1, 32'd1234, 32'd10, 32'd123, 32'd4, 65);
      repeat (9) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      chk("midrst_lo", result_lo, 32'd0);
      chk("midrst_hi", result_hi, 32'd0);
      sb.delete();
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      drive(1'b0, 32'd3, 32'd3, 32'd9, 32'd0, 33);                   wait_done();

      repeat (5) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Multi-cycle sequencer that runs 32-bit unsigned multiply (low word) and unsigned divide/remainder. It owns one private ALU instance and issues one ALU operation per cycle: ADD for shift-add multiply, SLT then SUB for restoring division. It sits beside the single-cycle execute stage and is started by the decoder for MUL/DIVU. It stalls the core through `busy` until `done`.

## Interface
- `WIDTH`, 32: operand/result width; only 32 is supported (the ALU is fixed 32-bit).
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  1  0=MUL, 1=DIVU; captured with `start`.
- `opa`  in  32  multiplicand / dividend; captured with `start`.
- `opb`  in  32  multiplier / divisor; captured with `start`.
- `busy`  out  1  high while an operation is in flight; reset 0.
- `done`  out  1  one-cycle pulse when results become valid; reset 0.
- `result_lo`  out  32  MUL: product[31:0]; DIVU: quotient; reset 0.
- `result_hi`  out  32  MUL: 0; DIVU: remainder; reset 0.

## Operation
- States: IDLE, MUL, DCMP, DSUB, DONE. Iteration counter: 5 bits.
- Accept: in IDLE or DONE with `start`=1, latch operands and clear `result_*`.
  - `op`=0: acc=0, mc=opa, mp=opb, cnt=0, go to MUL.
  - `op`=1 and `opb`=0: result_lo=32'hFFFF_FFFF, result_hi=opa, go to DONE.
  - `op`=1 otherwise: rem=0, quo=opa, cnt=0, go to DCMP.
- MUL (32 cycles): ALU ctrl 4'b0010, A=acc, B = mp[0] ? mc : 0. Then acc←result, mc←mc<<1, mp←mp>>1, cnt++. At cnt==31, go to DONE with result_lo=acc.
- DCMP: form rem_sh={rem[30:0],quo[31]} and shift quo left by 1. Latch ovf=rem[31]. ALU ctrl 4'b0111, A=rem_sh, B=divisor; latch lt=result[0]. Go to DSUB.
- DSUB: ALU ctrl 4'b0110, A=rem_sh, B=divisor.
  - If ovf or !lt: rem←result (32-bit wrap is correct when ovf=1) and quo[0]←1.
  - Else: rem←rem_sh.
  - cnt++. At cnt==31, go to DONE with result_lo=quo, result_hi=rem; otherwise go to DCMP.
- DONE: `done`=1 and `busy`=0 for one cycle. Go to IDLE unless a new `start` is accepted.
- `start` while `busy`=1 is ignored; no queuing, no error.
- `result_*` hold their values from DONE until the next accepted `start`.
- In IDLE the ALU is driven with ctrl 4'b0010, A=B=0; its `zero` output is unused.

## Timing
- `start` sampled at edge T.
  - `busy`=1 from T+1 until the DONE cycle.
  - MUL: `done` at T+33.
  - DIVU: `done` at T+65 (32 × DCMP+DSUB).
  - DIVU by zero: `done` at T+1, `busy` never asserted.
- Back-to-back: `start` during the DONE cycle is accepted at that edge. Next `done` follows with the same latency.
- Reset asserted mid-operation: immediately go to IDLE, all outputs 0, in-flight operation discarded. After `rst_n` rises, the first edge may accept `start`.
- Arithmetic is unsigned modulo 2^32. The ALU's SLT is an unsigned compare.

## Structure
- Shared package `alu_pkg`:
  - ALU control codes: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_NOR=4'b1100.
  - op encoding: OP_MUL=1'b0, OP_DIVU=1'b1.
  - Sequencer state enum.
- Sub-module: one instance of the existing `ALU`; all arithmetic goes through it. No other sub-modules; FSM, counter and shift registers are in this block.

## Test plan
- MUL 7×6: `start` at T → `done` at T+33, result_lo=42, result_hi=0; `busy` high T+1..T+32.
- MUL 32'hFFFF_FFFF×2 → result_lo=32'hFFFF_FFFE (wrap).
- DIVU 100/7 → `done` at T+65, result_lo=14, result_hi=2.
- DIVU 32'hFFFF_FFFF/32'h8000_0001 → result_lo=1, result_hi=32'h7FFF_FFFE (exercises the ovf path).
- DIVU 5/0 → `done` at T+1, result_lo=32'hFFFF_FFFF, result_hi=5. `start` pulsed mid-MUL is ignored and the result is unchanged.
- `rst_n` low at T+10 of a DIVU → all outputs 0 the same cycle. After release, MUL 3×3 → 9 at +33.
